// File: rtl/timer_setpoint_editor_if.sv
// Button/mode inputs and setpoint/display outputs of the countdown setpoint editor.
// master = stimulus side (buttons, switches); slave = the editor itself.
interface timer_setpoint_editor_if;
    logic       switch1;
    logic       switch2;
    logic       incrementar;
    logic       decrementar;
    logic       cambiar;
    logic       confirmar;
    logic [5:0] newSegundosT;
    logic [6:0] newMinutosT;
    logic       establecer;
    logic       blankSeg;
    logic       blankMin;
    logic       editing;

    modport master (
        output switch1, switch2, incrementar, decrementar, cambiar, confirmar,
        input  newSegundosT, newMinutosT, establecer, blankSeg, blankMin, editing
    );

    modport slave (
        input  switch1, switch2, incrementar, decrementar, cambiar, confirmar,
        output newSegundosT, newMinutosT, establecer, blankSeg, blankMin, editing
    );
endinterface

// File: rtl/timer_setpoint_editor.sv
// MM:SS countdown setpoint editor with hold-to-repeat steps, blink flags and active-low load strobe.
// Latency: button edge -> registered outputs on the same sampling edge; establecer low one cycle after commit.
// Backpressure: none; buttons are sampled every cycle and the timer must accept establecer when it pulses.
module timer_setpoint_editor #(
    parameter int MAX_MIN      = 99,
    parameter int REPEAT_DELAY = 4
) (
    input  logic                    clk2hz,
    input  logic                    reset,
    timer_setpoint_editor_if.slave  bus
);
    localparam int              HW       = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(REPEAT_DELAY);
    localparam logic [6:0]      MIN_TOP  = 7'(MAX_MIN);

    typedef enum logic [2:0] {IDLE, EDIT_SEC, EDIT_MIN, COMMIT, RUN} state_t;

    state_t         state, next_state;
    logic           prev_inc, prev_dec, prev_cam, prev_conf;
    logic [HW-1:0]  hold_inc, hold_dec, hold_inc_n, hold_dec_n;
    logic [5:0]     seg, seg_n;
    logic [6:0]     min, min_n;
    logic           phase, phase_n;
    logic           est_q, est_n, edt_q, edt_n, bs_q, bs_n, bm_q, bm_n;

    logic mode, inc_edge, dec_edge, cam_edge, conf_edge, both;
    logic step_ok, inc_step, dec_step, step_sec, step_min;

    assign mode      = bus.switch1 & bus.switch2;
    assign inc_edge  = bus.incrementar & ~prev_inc;
    assign dec_edge  = bus.decrementar & ~prev_dec;
    assign cam_edge  = bus.cambiar & ~prev_cam;
    assign conf_edge = bus.confirmar & ~prev_conf;
    assign both      = bus.incrementar & bus.decrementar;

    // Mode loss, confirm and field switch all pre-empt any value step in the same cycle.
    assign step_ok  = mode & ~conf_edge & ~cam_edge;
    assign inc_step = step_ok & ~both & bus.incrementar & (inc_edge | (hold_inc == HOLD_MAX));
    assign dec_step = step_ok & ~both & bus.decrementar & (dec_edge | (hold_dec == HOLD_MAX));
    assign step_sec = (state == EDIT_SEC) & (inc_step | dec_step);
    assign step_min = (state == EDIT_MIN) & (inc_step | dec_step);

    always_comb begin
        next_state = state;
        if (!mode) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     next_state = EDIT_SEC;
                EDIT_SEC: if (conf_edge) next_state = COMMIT;
                          else if (cam_edge) next_state = EDIT_MIN;
                EDIT_MIN: if (conf_edge) next_state = COMMIT;
                          else if (cam_edge) next_state = EDIT_SEC;
                COMMIT:   next_state = RUN;
                RUN:      if (cam_edge) next_state = EDIT_SEC;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        hold_inc_n = hold_inc;
        hold_dec_n = hold_dec;
        if (both || !bus.incrementar || inc_edge) hold_inc_n = '0;
        else if (hold_inc != HOLD_MAX)            hold_inc_n = hold_inc + 1'b1;
        if (both || !bus.decrementar || dec_edge) hold_dec_n = '0;
        else if (hold_dec != HOLD_MAX)            hold_dec_n = hold_dec + 1'b1;
    end

    always_comb begin
        seg_n = seg;
        min_n = min;
        if (step_sec) begin
            if (inc_step) seg_n = (seg == 6'd59) ? 6'd0 : seg + 6'd1;
            else          seg_n = (seg == 6'd0) ? 6'd59 : seg - 6'd1;
        end
        if (step_min) begin
            if (inc_step) min_n = (min == MIN_TOP) ? 7'd0 : min + 7'd1;
            else          min_n = (min == 7'd0) ? MIN_TOP : min - 7'd1;
        end
    end

    // Phase restarts visible whenever an edit field is (re)entered; a stepping field is never blanked.
    always_comb begin
        phase_n = 1'b0;
        if ((state == EDIT_SEC || state == EDIT_MIN) && next_state == state)
            phase_n = ~phase;
        bs_n  = phase_n & (next_state == EDIT_SEC) & ~step_sec;
        bm_n  = phase_n & (next_state == EDIT_MIN) & ~step_min;
        edt_n = (next_state == EDIT_SEC) || (next_state == EDIT_MIN);
        est_n = ~((state == COMMIT) & mode);
    end

    always_ff @(posedge clk2hz) begin
        if (reset) begin
            state     <= IDLE;
            prev_inc  <= 1'b1;
            prev_dec  <= 1'b1;
            prev_cam  <= 1'b1;
            prev_conf <= 1'b1;
            hold_inc  <= '0;
            hold_dec  <= '0;
            seg       <= '0;
            min       <= '0;
            phase     <= 1'b0;
            est_q     <= 1'b1;
            edt_q     <= 1'b0;
            bs_q      <= 1'b0;
            bm_q      <= 1'b0;
        end else begin
            state     <= next_state;
            prev_inc  <= bus.incrementar;
            prev_dec  <= bus.decrementar;
            prev_cam  <= bus.cambiar;
            prev_conf <= bus.confirmar;
            hold_inc  <= hold_inc_n;
            hold_dec  <= hold_dec_n;
            seg       <= seg_n;
            min       <= min_n;
            phase     <= phase_n;
            est_q     <= est_n;
            edt_q     <= edt_n;
            bs_q      <= bs_n;
            bm_q      <= bm_n;
        end
    end

    assign bus.newSegundosT = seg;
    assign bus.newMinutosT  = min;
    assign bus.establecer   = est_q;
    assign bus.editing      = edt_q;
    assign bus.blankSeg     = bs_q;
    assign bus.blankMin     = bm_q;
endmodule

// File: tb/tb_timer_setpoint_editor.sv
// Directed per-cycle vector table for the setpoint editor plus a commit-strobe window sequence.
module tb_timer_setpoint_editor;
    logic clk2hz;
    logic reset;
    timer_setpoint_editor_if bus();

    timer_setpoint_editor #(.MAX_MIN(99), .REPEAT_DELAY(4)) dut (
        .clk2hz (clk2hz),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk2hz = 1'b0;
    always #5 clk2hz = ~clk2hz;

    typedef struct {
        int rst, s1, s2, inc, dec, cam, conf;
        int seg, min, est, edt, bs, bm, chkb;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input int rst, s1, s2, inc, dec, cam, conf,
                       input int seg, min, est, edt, bs, bm, chkb);
        vec_t v;
        v.rst = rst; v.s1 = s1; v.s2 = s2; v.inc = inc; v.dec = dec; v.cam = cam; v.conf = conf;
        v.seg = seg; v.min = min; v.est = est; v.edt = edt; v.bs = bs; v.bm = bm; v.chkb = chkb;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input int rst, s1, s2, inc, dec, cam, conf);
        reset           = rst[0];
        bus.switch1     = s1[0];
        bus.switch2     = s2[0];
        bus.incrementar = inc[0];
        bus.decrementar = dec[0];
        bus.cambiar     = cam[0];
        bus.confirmar   = conf[0];
    endtask

    initial begin
        int low_cnt, low_pos;
        drive(1, 0, 0, 0, 0, 0, 0);

        //  rst s1 s2 inc dec cam conf | seg min est edt bs bm chkb
        add(1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   1, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   2, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   2, 0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   3, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   3, 0, 1, 1, 1, 0, 1);
        // seconds down through 0 to 59, then back up to 0
        add(0, 1, 1, 0, 1, 0, 0,   2, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   2, 0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0,   1, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0,  59, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,  59, 0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0, 1);
        // switch to minutes, hold inc for 10 cycles: steps at 0,5,6,7,8,9
        add(0, 1, 1, 0, 0, 1, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 1, 0, 1, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 1, 0, 1, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 2, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 3, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 4, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 5, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 6, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 6, 1, 1, 0, 1, 1);
        // hold dec for 11 cycles: 6 -> 0 -> MAX_MIN
        add(0, 1, 1, 0, 1, 0, 0,   0, 5, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 5, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 5, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 5, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 5, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 4, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 3, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 2, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0,   0,99, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0,   0,99, 1, 1, 0, 1, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 1, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 1, 0, 1, 1);
        // commit, RUN ignores inc/dec, cambiar returns to seconds edit
        add(0, 1, 1, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 1, 1, 0, 1);
        // confirm + inc on the same edge: commit wins, no step
        add(0, 1, 1, 1, 0, 0, 1,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0,   0, 1, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 1, 1, 0, 1);
        // mode loss while in COMMIT: no strobe
        add(0, 1, 1, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   1, 1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   1, 1, 1, 1, 0, 0, 1);
        // reset mid-edit with inc held through it
        add(1, 1, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 1, 0, 1);
        add(0, 1, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0, 1);
        // reset while in COMMIT: no strobe
        add(0, 1, 1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 1, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk2hz);
            drive(vecs[i].rst, vecs[i].s1, vecs[i].s2, vecs[i].inc,
                  vecs[i].dec, vecs[i].cam, vecs[i].conf);
            @(posedge clk2hz);
            #1;
            chk("seconds",    i, int'(bus.newSegundosT), vecs[i].seg);
            chk("minutes",    i, int'(bus.newMinutosT),  vecs[i].min);
            chk("establecer", i, int'(bus.establecer),   vecs[i].est);
            chk("editing",    i, int'(bus.editing),      vecs[i].edt);
            if (vecs[i].chkb != 0) begin
                chk("blankSeg", i, int'(bus.blankSeg), vecs[i].bs);
                chk("blankMin", i, int'(bus.blankMin), vecs[i].bm);
            end
        end

        // Commit window: one inc to seconds=1, then confirm; strobe must be low on the 2nd edge only.
        @(negedge clk2hz); drive(0, 1, 1, 1, 0, 0, 0);
        @(negedge clk2hz); drive(0, 1, 1, 0, 0, 0, 0);
        @(negedge clk2hz); drive(0, 1, 1, 0, 0, 0, 1);
        low_cnt = 0;
        low_pos = -1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk2hz);
            #1;
            if (bus.establecer == 1'b0) begin
                low_cnt++;
                if (low_pos < 0) low_pos = c;
            end
            chk("window_seconds", c, int'(bus.newSegundosT), 1);
            chk("window_minutes", c, int'(bus.newMinutosT), 0);
            @(negedge clk2hz);
            drive(0, 1, 1, 0, 0, 0, 0);
        end
        chk("strobe_low_cycles", 0, low_cnt, 1);
        chk("strobe_position",   0, low_pos, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
